mc_ctrl_fsm: RTL

- Multicycle MIPS main control FSM; sequences the datapath and the ALU by driving ALUOp into the ALU-control decoder.
- Drives all mux selects and write enables: PC, instruction register, memory, register file.
- Consumes Opcode from the IR, Zero/Overflow from the ALU, and the decoded Break flag.
- Fixed-latency memory handled by an internal wait counter.

---
 rtl/mc_ctrl_fsm.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main control FSM: sequences PC/IR/memory/regfile/ALU per instruction phase.
// Latency: FETCH and MEMREAD last MEM_WAIT+1 cycles, every other state 1 cycle; Moore outputs.
// Backpressure: none; fixed-latency memory covered by an internal wait counter. Option: MC_CTRL_EXCEPTION_EN.
module mc_ctrl_fsm #(
  parameter int unsigned MEM_WAIT       = 1,
  parameter logic [1:0]  EXC_VECTOR_SEL = 2'b11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       Break,
  input  logic       Zero,
  input  logic       Overflow,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       EPCWrite,
  output logic       Halted,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,  S_DECODE   = 4'd1,  S_MEMADDR  = 4'd2,  S_MEMREAD = 4'd3,
    S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5,  S_RTYPE_EX = 4'd6,  S_RTYPE_WB = 4'd7,
    S_ADDI_EX  = 4'd8,  S_ADDI_WB  = 4'd9,  S_BRANCH   = 4'd10, S_JUMP    = 4'd11,
    S_HALT     = 4'd12, S_EXC      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       last_cycle;
  logic       pcw_raw, mr_raw, mw_raw, irw_raw, rw_raw, epc_raw, halt_raw;

  assign last_cycle = (cnt_q == WAIT_LAST);
  assign State      = state_q;

  // Enables and strobes are suppressed while reset is held so nothing half-finished commits.
  assign PCWrite  = pcw_raw  & ~reset;
  assign MemRead  = mr_raw   & ~reset;
  assign MemWrite = mw_raw   & ~reset;
  assign IRWrite  = irw_raw  & ~reset;
  assign RegWrite = rw_raw   & ~reset;
  assign EPCWrite = epc_raw  & ~reset;
  assign Halted   = halt_raw & ~reset;

`ifndef MC_CTRL_EXCEPTION_EN
  // Overflow and the exception vector select only matter when exceptions are built in.
  logic unused_exc;
  assign unused_exc = Overflow ^ (^EXC_VECTOR_SEL);
`endif

  // State register and memory wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state selection; the counter restarts on every state change and only runs in read states.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    state_d = last_cycle ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE:      state_d = S_RTYPE_EX;
          OP_LW, OP_SW:  state_d = S_MEMADDR;
          OP_ADDI:       state_d = S_ADDI_EX;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
`ifdef MC_CTRL_EXCEPTION_EN
          default:       state_d = S_EXC;
`else
          default:       state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADDR:  state_d = (Opcode == OP_LW) ? S_MEMREAD : ((Opcode == OP_SW) ? S_MEMWRITE : S_FETCH);
      S_MEMREAD:  state_d = last_cycle ? S_MEMWB : S_MEMREAD;
      S_RTYPE_EX: begin
        if (Break)         state_d = S_HALT;
`ifdef MC_CTRL_EXCEPTION_EN
        else if (Overflow) state_d = S_EXC;
`endif
        else               state_d = S_RTYPE_WB;
      end
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
    cnt_d = '0;
    if ((state_d == state_q) && ((state_q == S_FETCH) || (state_q == S_MEMREAD)))
      cnt_d = cnt_q + 3'd1;
  end

  // Moore output decode from the registered state (branch PCWrite also looks at Zero/Opcode).
  always_comb begin
    pcw_raw  = 1'b0; mr_raw   = 1'b0; mw_raw  = 1'b0; irw_raw = 1'b0;
    rw_raw   = 1'b0; epc_raw  = 1'b0; halt_raw = 1'b0;
    IorD     = 1'b0; RegDst   = 1'b0; MemtoReg = 1'b0; ALUSrcA = 1'b0;
    ALUSrcB  = 2'b00; ALUOp   = 3'b000; PCSource = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        mr_raw = 1'b1;
        if (last_cycle) begin
          irw_raw = 1'b1;
          ALUSrcB = 2'b01;
          pcw_raw = 1'b1;
        end
      end
      S_DECODE:   ALUSrcB = 2'b11;
      S_MEMADDR:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
      S_MEMREAD:  begin mr_raw = 1'b1; IorD = 1'b1; end
      S_MEMWB:    begin MemtoReg = 1'b1; rw_raw = 1'b1; end
      S_MEMWRITE: begin IorD = 1'b1; mw_raw = 1'b1; end
      S_RTYPE_EX: begin ALUSrcA = 1'b1; ALUOp = 3'b010; end
      S_RTYPE_WB: begin RegDst = 1'b1; rw_raw = 1'b1; end
      S_ADDI_EX:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
      S_ADDI_WB:  rw_raw = 1'b1;
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 3'b001;
        PCSource = 2'b01;
        pcw_raw  = ((Opcode == OP_BEQ) && Zero) || ((Opcode == OP_BNE) && !Zero);
      end
      S_JUMP:     begin PCSource = 2'b10; pcw_raw = 1'b1; end
      S_HALT:     halt_raw = 1'b1;
`ifdef MC_CTRL_EXCEPTION_EN
      S_EXC:      begin epc_raw = 1'b1; PCSource = EXC_VECTOR_SEL; pcw_raw = 1'b1; end
`endif
      default: ;
    endcase
  end

endmodule
